// File: rtl/traffic_mode_controller.sv
// traffic_mode_controller
//   Registered mode controller for the traffic-light front end. Holds per-lane
//   capacity and occupancy, and sequences LOAD / ADD / MANUAL / AUTO modes.
//   AUTO serves non-empty lanes round-robin: a green turn drains one car every
//   DRAIN_TICKS cycles (at most MAX_DEPART cars), followed by ALLRED_TICKS
//   cycles of all-red clearance.
// Ports:
//   clock, reset_n      rising-edge clock, async active-low reset
//   mode                00 LOAD, 01 ADD, 10 MANUAL, 11 AUTO
//   lane_sel            target lane for LOAD / ADD / MANUAL
//   cap_in              capacity value written on a LOAD event
//   load_strobe         load request (edge-detected)
//   car_strobe          car arrival / manual departure (edge-detected)
//   capacity, occupancy packed per lane, lane i at [i*CAP_W +: CAP_W]
//   green               one-hot or zero lane lights
//   full                occupancy == capacity, decoded from registers
//   overflow            one-cycle pulse on a rejected arrival
//   auto_state          00 PICK, 01 GREEN, 10 ALLRED

// Per-lane capacity/occupancy register pair with saturating update.
module traffic_lane #(
    parameter int CAP_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CAP_W-1:0] cap_in,
    input  logic             inc,
    input  logic             dec,
    output logic [CAP_W-1:0] cap,
    output logic [CAP_W-1:0] occ,
    output logic             ovf
);
    logic [CAP_W-1:0] cap_q, cap_d;
    logic [CAP_W-1:0] occ_q, occ_d;

    always_comb begin
        cap_d = cap_q;
        occ_d = occ_q;
        ovf   = 1'b0;
        if (load) begin
            cap_d = cap_in;
            if (occ_q > cap_in) occ_d = cap_in;
        end else if (inc && !dec) begin
            if (occ_q < cap_q) occ_d = occ_q + CAP_W'(1);
            else               ovf   = 1'b1;
        end else if (dec && !inc) begin
            if (occ_q != '0) occ_d = occ_q - CAP_W'(1);
        end
        // inc && dec together: the arrival replaces the departing car
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cap_q <= '1;
            occ_q <= '0;
        end else begin
            cap_q <= cap_d;
            occ_q <= occ_d;
        end
    end

    assign cap = cap_q;
    assign occ = occ_q;
endmodule

module traffic_mode_controller #(
    parameter int NUM_LANES    = 4,
    parameter int LANE_W       = 2,
    parameter int CAP_W        = 4,
    parameter int DRAIN_TICKS  = 4,
    parameter int MAX_DEPART   = 3,
    parameter int ALLRED_TICKS = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [1:0]                 mode,
    input  logic [LANE_W-1:0]          lane_sel,
    input  logic [CAP_W-1:0]           cap_in,
    input  logic                       load_strobe,
    input  logic                       car_strobe,
    output logic [NUM_LANES*CAP_W-1:0] capacity,
    output logic [NUM_LANES*CAP_W-1:0] occupancy,
    output logic [NUM_LANES-1:0]       green,
    output logic [NUM_LANES-1:0]       full,
    output logic                       overflow,
    output logic [1:0]                 auto_state
);
    localparam logic [1:0] M_LOAD = 2'b00, M_ADD = 2'b01, M_MAN = 2'b10, M_AUTO = 2'b11;
    localparam int LIDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int DRW    = (DRAIN_TICKS > 1) ? $clog2(DRAIN_TICKS) : 1;
    localparam int CLW    = (ALLRED_TICKS > 1) ? $clog2(ALLRED_TICKS) : 1;
    localparam int DPW    = $clog2(MAX_DEPART + 1);

    typedef enum logic [1:0] {PICK = 2'b00, GREEN = 2'b01, ALLRED = 2'b10} auto_st_e;

    auto_st_e          state_q, state_d;
    logic [LANE_W-1:0] cur_q, cur_d, last_q, last_d;
    logic [DRW-1:0]    drain_q, drain_d;
    logic [DPW-1:0]    dep_q, dep_d;
    logic [CLW-1:0]    clr_q, clr_d;
    logic [1:0]        mode_prev_q;
    logic              load_prev_q, car_prev_q;
    logic [NUM_LANES-1:0] green_q, green_d;
    logic              overflow_q, overflow_d;

    logic [CAP_W-1:0]     cap_w [NUM_LANES];
    logic [CAP_W-1:0]     occ_w [NUM_LANES];
    logic [NUM_LANES-1:0] ovf_w, nz_w;

    logic             load_ev, car_ev, mode_chg, lane_ok, auto_dep, found;
    logic [CAP_W-1:0] occ_cur;
    logic [LANE_W-1:0] pick_lane;
    int               idx;

    assign load_ev  = load_strobe & ~load_prev_q;
    assign car_ev   = car_strobe & ~car_prev_q;
    assign mode_chg = (mode != mode_prev_q);
    assign lane_ok  = (int'(lane_sel) < NUM_LANES);

    // Per-lane request decode and storage
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic sel, ld, inc, dec;
            assign sel = lane_ok && (lane_sel == LANE_W'(gi));
            assign ld  = load_ev && (mode == M_LOAD) && sel;
            assign inc = car_ev && ((mode == M_ADD) || (mode == M_AUTO)) && sel;
            assign dec = (car_ev && (mode == M_MAN) && sel) ||
                         (auto_dep && (cur_q == LANE_W'(gi)));

            traffic_lane #(.CAP_W(CAP_W)) u_lane (
                .clock   (clock),
                .reset_n (reset_n),
                .load    (ld),
                .cap_in  (cap_in),
                .inc     (inc),
                .dec     (dec),
                .cap     (cap_w[gi]),
                .occ     (occ_w[gi]),
                .ovf     (ovf_w[gi])
            );

            assign nz_w[gi] = (occ_w[gi] != '0);
            assign full[gi] = (occ_w[gi] == cap_w[gi]);
            assign capacity[gi*CAP_W +: CAP_W]  = cap_w[gi];
            assign occupancy[gi*CAP_W +: CAP_W] = occ_w[gi];
        end
    endgenerate

    // Round-robin search starting after the last served lane
    always_comb begin
        found     = 1'b0;
        pick_lane = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_LANES; k++) begin
            idx = (int'(last_q) + k) % NUM_LANES;
            if (!found && nz_w[LIDX_W'(idx)]) begin
                found     = 1'b1;
                pick_lane = LANE_W'(idx);
            end
        end
    end

    always_comb begin
        occ_cur = '0;
        for (int j = 0; j < NUM_LANES; j++)
            if (cur_q == LANE_W'(j)) occ_cur = occ_w[j];
    end

    // AUTO sequencer: next state and departure strobe
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        last_d   = last_q;
        drain_d  = drain_q;
        dep_d    = dep_q;
        clr_d    = clr_q;
        auto_dep = 1'b0;
        if (mode != M_AUTO || mode_chg) begin
            // Outside AUTO, or on any mode change, park in PICK with clean counters
            state_d = PICK;
            drain_d = '0;
            dep_d   = '0;
            clr_d   = '0;
        end else begin
            case (state_q)
                PICK: begin
                    if (found) begin
                        state_d = GREEN;
                        cur_d   = pick_lane;
                        drain_d = '0;
                        dep_d   = '0;
                    end
                end
                GREEN: begin
                    if (occ_cur == '0) begin
                        // Lane emptied behind our back (e.g. reloaded): end turn now
                        state_d = ALLRED;
                        last_d  = cur_q;
                        clr_d   = '0;
                    end else if (drain_q == DRW'(DRAIN_TICKS - 1)) begin
                        auto_dep = 1'b1;
                        drain_d  = '0;
                        dep_d    = dep_q + DPW'(1);
                        // Leave on the edge of the departure that ends the turn
                        if (occ_cur == CAP_W'(1) || dep_q == DPW'(MAX_DEPART - 1)) begin
                            state_d = ALLRED;
                            last_d  = cur_q;
                            clr_d   = '0;
                        end
                    end else begin
                        drain_d = drain_q + DRW'(1);
                    end
                end
                ALLRED: begin
                    if (clr_q == CLW'(ALLRED_TICKS - 1)) begin
                        state_d = PICK;
                        clr_d   = '0;
                    end else begin
                        clr_d = clr_q + CLW'(1);
                    end
                end
                default: state_d = PICK;
            endcase
        end
    end

    // Lights are registered from the next-state so they line up with auto_state
    always_comb begin
        green_d = '0;
        for (int j = 0; j < NUM_LANES; j++) begin
            if (mode == M_MAN)
                green_d[j] = lane_ok && (lane_sel == LANE_W'(j));
            else if (mode == M_AUTO)
                green_d[j] = (state_d == GREEN) && (cur_d == LANE_W'(j));
        end
        overflow_d = |ovf_w;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= PICK;
            cur_q       <= '0;
            last_q      <= LANE_W'(NUM_LANES - 1);
            drain_q     <= '0;
            dep_q       <= '0;
            clr_q       <= '0;
            mode_prev_q <= 2'b00;
            load_prev_q <= 1'b0;
            car_prev_q  <= 1'b0;
            green_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            drain_q     <= drain_d;
            dep_q       <= dep_d;
            clr_q       <= clr_d;
            mode_prev_q <= mode;
            load_prev_q <= load_strobe;
            car_prev_q  <= car_strobe;
            green_q     <= green_d;
            overflow_q  <= overflow_d;
        end
    end

    assign green      = green_q;
    assign overflow   = overflow_q;
    assign auto_state = state_q;
endmodule

// File: tb/tb_traffic_mode_controller.sv
// Directed bench for traffic_mode_controller. LANE_W is widened to 3 so an
// out-of-range lane_sel (5) can be driven with NUM_LANES = 4.
module tb_traffic_mode_controller;
    localparam int NL = 4, LW = 3, CW = 4;

    logic            clock, reset_n;
    logic [1:0]      mode;
    logic [LW-1:0]   lane_sel;
    logic [CW-1:0]   cap_in;
    logic            load_strobe, car_strobe;
    logic [NL*CW-1:0] capacity, occupancy;
    logic [NL-1:0]   green, full;
    logic            overflow;
    logic [1:0]      auto_state;

    int n_cmp = 0, n_bad = 0, ovf_cnt = 0, c0;

    traffic_mode_controller #(
        .NUM_LANES(NL), .LANE_W(LW), .CAP_W(CW),
        .DRAIN_TICKS(4), .MAX_DEPART(3), .ALLRED_TICKS(2)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .mode        (mode),
        .lane_sel    (lane_sel),
        .cap_in      (cap_in),
        .load_strobe (load_strobe),
        .car_strobe  (car_strobe),
        .capacity    (capacity),
        .occupancy   (occupancy),
        .green       (green),
        .full        (full),
        .overflow    (overflow),
        .auto_state  (auto_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) if (overflow === 1'b1) ovf_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic car_pulse();
        car_strobe = 1'b1; tick(1);
        car_strobe = 1'b0; tick(1);
    endtask

    task automatic load_pulse();
        load_strobe = 1'b1; tick(1);
        load_strobe = 1'b0; tick(1);
    endtask

    function automatic logic [CW-1:0] occ_of(input int l);
        return occupancy[l*CW +: CW];
    endfunction

    task automatic wait_green(input string tag);
        for (int i = 0; i < 12 && auto_state != 2'b01; i++) tick(1);
        chk(tag, auto_state, 2'b01);
    endtask

    initial begin
        reset_n = 1'b0; mode = 2'b00; lane_sel = '0; cap_in = '0;
        load_strobe = 1'b0; car_strobe = 1'b0;
        tick(2);
        chk("rst_cap", capacity, 16'hFFFF);
        chk("rst_occ", occupancy, 16'h0000);
        chk("rst_green", green, 4'b0000);
        chk("rst_state", auto_state, 2'b00);
        chk("rst_full", full, 4'b0000);
        chk("rst_ovf", overflow, 1'b0);
        reset_n = 1'b1;
        tick(1);

        // LOAD lane 2 = 3, then four arrivals: saturate and overflow once
        mode = 2'b00; lane_sel = 3'd2; cap_in = 4'd3;
        load_pulse();
        chk("load_cap2", capacity, 16'hF3FF);
        mode = 2'b01;
        for (int e = 1; e <= 4; e++) begin
            c0 = ovf_cnt;
            car_pulse();
            chk($sformatf("add_occ2_%0d", e), occ_of(2), (e > 3) ? 3 : e);
            chk($sformatf("add_ovf_%0d", e), ovf_cnt - c0, (e == 4) ? 1 : 0);
        end
        chk("full2", full, 4'b0100);

        // Clamp on reload, then invalid lane has no effect
        mode = 2'b00; cap_in = 4'd1;
        load_pulse();
        chk("clamp_occ2", occ_of(2), 4'd1);
        chk("clamp_cap", capacity, 16'hF1FF);
        lane_sel = 3'd5; cap_in = 4'd7;
        load_pulse();
        chk("inv_load_cap", capacity, 16'hF1FF);
        chk("inv_load_occ", occupancy, 16'h0100);
        mode = 2'b01; c0 = ovf_cnt;
        car_pulse();
        chk("inv_add_occ", occupancy, 16'h0100);
        chk("inv_add_ovf", ovf_cnt - c0, 0);
        mode = 2'b10;
        tick(2);
        chk("inv_man_green", green, 4'b0000);

        // Build occupancy {0,5,0,2}; last served is still lane 3
        mode = 2'b00; lane_sel = 3'd2; cap_in = 4'hF;
        load_pulse();
        mode = 2'b01;
        repeat (4) car_pulse();
        lane_sel = 3'd0;
        repeat (2) car_pulse();
        chk("auto_setup", occupancy, 16'h0502);

        mode = 2'b11;
        wait_green("enter_green0");               // GREEN cycle 1
        chk("g0_green", green, 4'b0001);
        tick(3);                                  // cycle 4
        chk("g0_c4_occ", occ_of(0), 4'd2);
        tick(1);                                  // cycle 5
        chk("g0_c5_occ", occ_of(0), 4'd1);
        tick(3);                                  // cycle 8
        chk("g0_c8_occ", occ_of(0), 4'd1);
        chk("g0_c8_state", auto_state, 2'b01);
        tick(1);
        chk("g0_done_occ", occ_of(0), 4'd0);
        chk("allred1_state", auto_state, 2'b10);
        chk("allred1_green", green, 4'b0000);
        tick(1);
        chk("allred2_state", auto_state, 2'b10);
        tick(1);
        chk("pick_state", auto_state, 2'b00);
        tick(1);
        chk("g2_state", auto_state, 2'b01);
        chk("g2_green", green, 4'b0100);
        tick(11);                                 // cycle 12 of lane 2 turn
        chk("g2_c12_occ", occ_of(2), 4'd3);
        tick(1);
        chk("g2_done_state", auto_state, 2'b10);
        chk("g2_done_occ", occ_of(2), 4'd2);
        tick(2);
        chk("pick2_state", auto_state, 2'b00);
        tick(1);
        chk("g2_again_green", green, 4'b0100);

        // Asynchronous reset mid-green, checked before any clock edge
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_green", green, 4'b0000);
        chk("async_occ", occupancy, 16'h0000);
        chk("async_cap", capacity, 16'hFFFF);
        chk("async_state", auto_state, 2'b00);
        mode = 2'b00;
        tick(1);
        reset_n = 1'b1;
        tick(1);

        // Lane 1 full at 4: arrival on the same edge as a departure
        lane_sel = 3'd1; cap_in = 4'd4;
        load_pulse();
        mode = 2'b01;
        repeat (4) car_pulse();
        chk("l1_occ", occ_of(1), 4'd4);
        chk("l1_full", full, 4'b0010);
        mode = 2'b11;
        wait_green("enter_green1");
        chk("g1_green", green, 4'b0010);
        tick(3);                                  // cycle 4: departure edge ahead
        c0 = ovf_cnt;
        car_strobe = 1'b1;
        tick(1);
        car_strobe = 1'b0;
        chk("simul_occ", occ_of(1), 4'd4);
        chk("simul_ovf_now", overflow, 1'b0);
        tick(1);
        chk("simul_ovf_cnt", ovf_cnt - c0, 0);
        chk("simul_state", auto_state, 2'b01);

        // MANUAL: held strobe gives exactly one decrement
        mode = 2'b10; lane_sel = 3'd1;
        tick(1);
        chk("man_green", green, 4'b0010);
        chk("man_state", auto_state, 2'b00);
        car_pulse();
        car_pulse();
        chk("man_occ2", occ_of(1), 4'd2);
        car_strobe = 1'b1;
        tick(10);
        chk("man_hold_occ", occ_of(1), 4'd1);
        car_strobe = 1'b0;
        mode = 2'b01;
        tick(1);
        chk("add_green", green, 4'b0000);
        chk("add_keep_occ", occ_of(1), 4'd1);
        mode = 2'b10; lane_sel = 3'd3;
        car_pulse();
        chk("man_zero", occupancy, 16'h0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
